// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: widths, opcodes and FSM state encoding.
// The optional multiplier is enabled with the EXEC_MUL_EN macro.
package exec_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SLL = 3'd5;
  localparam logic [OP_W-1:0] OP_SRL = 3'd6;
  localparam logic [OP_W-1:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } exec_state_e;
endpackage

// File: rtl/exec_if.sv
// Issue and register-file write-port bundle between the operand stage and exec_unit.
// Handshake: an issue fires on a rising clk edge where in_valid && in_ready; op/a/b/dst are
// sampled only then, and the master must hold them while in_ready is low.
interface exec_if;
  import exec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [ADDR_W-1:0] dst;
  logic              regwrite;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              flag_z;
  logic              flag_c;
  logic              illegal;

  modport master (
    output in_valid, op, a, b, dst,
    input  in_ready, regwrite, wa, wd, flag_z, flag_c, illegal
  );

  modport slave (
    input  in_valid, op, a, b, dst,
    output in_ready, regwrite, wa, wd, flag_z, flag_c, illegal
  );
endinterface

// File: rtl/exec_mul_seq.sv
// Shift-add multiplier: start_i loads operands, then one partial product per cycle for W
// cycles; done_o flags the last iteration, with result_o carrying the truncated product.
module exec_mul_seq
  import exec_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] result_o
);
  localparam int CNT_W = $clog2(W);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     mcand_q;
  logic [W-1:0]     mplier_q;
  logic [W-1:0]     acc_q;
  logic [W-1:0]     acc_d;

  assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o   = busy_q && (cnt_q == CNT_W'(W - 1));
  // Exposing acc_d lets the caller capture the product on the same edge as the last step.
  assign result_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/exec_unit.sv
// Execute stage feeding the register-file write port. Single-cycle ALU ops; op 7 runs the
// shift-add multiplier when EXEC_MUL_EN is defined, otherwise it pulses illegal.
module exec_unit
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  exec_if.slave       bus,
  output exec_state_e dbg_state_o
);
  exec_state_e       state_q, state_d;
  logic              fire;
  logic [DATA_W:0]   alu_full;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              fz_q, fz_d;
  logic              fc_q, fc_d;
  logic              illegal_q, illegal_d;

  // Gating ready with rst makes reset win over a same-cycle issue.
  assign bus.in_ready = ~rst && (state_q == S_IDLE);
  assign fire         = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_full = '0;
    case (bus.op)
      OP_ADD:  alu_full = {1'b0, bus.a} + {1'b0, bus.b};
      OP_SUB:  alu_full = {1'b0, bus.a} - {1'b0, bus.b};
      OP_AND:  alu_full = {1'b0, bus.a & bus.b};
      OP_OR:   alu_full = {1'b0, bus.a | bus.b};
      OP_XOR:  alu_full = {1'b0, bus.a ^ bus.b};
      OP_SLL:  alu_full = {1'b0, bus.a << bus.b[2:0]};
      OP_SRL:  alu_full = {1'b0, bus.a >> bus.b[2:0]};
      default: alu_full = '0;
    endcase
  end
  assign alu_res = alu_full[DATA_W-1:0];
  assign alu_c   = alu_full[DATA_W];

`ifdef EXEC_MUL_EN
  logic              mul_done;
  logic [DATA_W-1:0] mul_res;
  logic [ADDR_W-1:0] dst_q;

  exec_mul_seq #(.W(DATA_W)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (fire && (bus.op == OP_MUL)),
    .a_i      (bus.a),
    .b_i      (bus.b),
    .done_o   (mul_done),
    .result_o (mul_res)
  );

  always_ff @(posedge clk) begin
    if (rst) dst_q <= '0;
    else if (fire) dst_q <= bus.dst;
  end
`endif

  always_comb begin
    state_d    = state_q;
    regwrite_d = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    fz_d       = fz_q;
    fc_d       = fc_q;
    illegal_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          if (bus.op == OP_MUL) begin
`ifdef EXEC_MUL_EN
            state_d = S_MUL;
`else
            illegal_d = 1'b1;
`endif
          end else begin
            regwrite_d = (bus.dst != '0);
            wa_d       = bus.dst;
            wd_d       = alu_res;
            fz_d       = (alu_res == '0);
            fc_d       = alu_c;
          end
        end
      end
`ifdef EXEC_MUL_EN
      // The write is registered on the last iteration so it is visible during DONE.
      S_MUL: begin
        if (mul_done) begin
          state_d    = S_DONE;
          regwrite_d = (dst_q != '0);
          wa_d       = dst_q;
          wd_d       = mul_res;
          fz_d       = (mul_res == '0);
          fc_d       = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      fz_q       <= 1'b0;
      fc_q       <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      fz_q       <= fz_d;
      fc_q       <= fc_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.regwrite = regwrite_q;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign bus.flag_z   = fz_q;
  assign bus.flag_c   = fc_q;
  assign bus.illegal  = illegal_q;
  assign dbg_state_o  = state_q;
endmodule
